usb11_recv: RTL
===============

# usb11_recv

Low-speed (1.5 Mbit/s) USB receive path for the thin-client USB host. It recovers bit timing from the dp/dm lines by 8x oversampling at 12 MHz, detects SYNC, and NRZI-decodes and bit-unstuffs the stream. Received bytes go out LSB-first-assembled with packet start/end and error strobes. It sits beside usb11_send on the same bus pair and listens only while the transmitter is not driving the bus.

## Interface
Parameters:
- SYNC_MIN_ZEROS, 3: minimum decoded zeros before the terminating 1 for SYNC to be accepted (tolerates hub-truncated SYNC).

Ports:
- clk  input  1  12 MHz clock.
- rst  input  1  reset, synchronous, active-low.
- dp  input  1  raw USB D+ line (asynchronous).
- dm  input  1  raw USB D- line (asynchronous).
- rx_ena  input  1  1 = listen; drive from !bus_enable of usb11_send.
- rbyte  output  8  last received byte, held until the next rbyte_valid.
- rbyte_valid  output  1  one-cycle strobe, new rbyte.
- pkt_start  output  1  one-cycle strobe on SYNC accepted.
- pkt_end  output  1  one-cycle strobe on valid EOP (SE0 then J).
- err  output  1  one-cycle strobe on stuff, alignment or SE1 error.
- crc_ok  output  1  CRC16 check result, valid in the cycle of pkt_end.

## Operation
- Line state (low speed): J = dm1/dp0, K = dp1/dm0, SE0 = 00, SE1 = 11.
- dp/dm pass through a 2-flop synchronizer, then a line-state register.
- DPLL: 3-bit phase counter. It clears to 0 on any J↔K change and otherwise increments. The sample strobe fires at phase == 3 (mid-bit). Without edges it free-runs with period 8.
- NRZI: decoded bit = 1 if the sampled state equals the previous sample, else 0. The previous state is J on entry to SYNC.
- States:
  - IDLE: entered on reset or rx_ena = 0. On the first K, go to SYNC.
  - SYNC: count decoded zeros. A decoded 1 after ≥ SYNC_MIN_ZEROS zeros goes to DATA and pulses pkt_start. A 1 with fewer zeros, or SE0, goes to IDLE.
  - DATA:
    - A ones counter counts consecutive decoded 1s and clears on a 0.
    - When the counter is 6, the next sample is a stuff bit. If it is 0, drop it and clear the counter. If it is 1, raise a stuff error.
    - Data bits shift into rbyte MSB-in (LSB first on the wire); a 3-bit counter tracks them.
    - On the 8th bit, pulse rbyte_valid.
    - A sampled SE0 goes to EOP.
  - EOP:
    - Sampled J: pulse pkt_end and go to IDLE.
    - Sampled K or SE1: error.
    - More than 3 consecutive SE0 samples: go to IDLE without pkt_end (bus reset).
  - WAIT_IDLE:
    - Entered on any error, and err pulses.
    - Exits to IDLE after 8 consecutive J samples or SE0 followed by J.
    - No rbyte_valid or pkt_end is produced in this state.
- Alignment: at SE0 in DATA, a bit count of 0 or 1 (one dribble bit) is accepted and the dribble is discarded. Any other count is an error with no pkt_end.
- SE1 sampled in SYNC or DATA is an error.
- rx_ena = 0 forces IDLE in the next cycle from any state, with no strobes.

## Timing
- Reset (rst = 0 at a clk edge): all outputs 0, rbyte = 8'h00, state IDLE, phase 0.
- Pipeline: 2 sync + 1 line-state register. An edge on the pins reaches the phase counter 3 cycles later.
- rbyte_valid, pkt_start and pkt_end assert in the cycle after the sample strobe that completes them. Two strobes never coincide.
- Tolerates bit periods of 7–9 clocks sustained across a packet, because the phase is re-aligned at every transition (guaranteed at least every 7 bits).
- crc_ok is 0 at all times other than the pkt_end cycle.

## Configuration
- USB11_RECV_CRC16_EN:
  - Defined: a 16-bit CRC register is initialised to 16'hFFFF at pkt_start. It is updated from every data bit after the first byte (the PID) with polynomial 16'h8005, MSB-shift form. crc_ok = (crc == 16'h800D) at pkt_end.
  - Undefined: no CRC logic is built; crc_ok = pkt_end.

## Structure
- Package usb11_pkg:
  - line-state encodings LS_SE0, LS_J, LS_K, LS_SE1;
  - receiver state enum;
  - CRC16_POLY and CRC16_RESIDUAL;
  - BIT_PHASE_SAMPLE = 3.
- Sub-module usb11_rx_dpll: synchronizer, line-state register, edge detect, phase counter. Outputs the line state and a sample strobe.

## Test plan
- Reset: rst = 0 for 3 clocks with the bus in J → all outputs 0; no strobes for 100 idle cycles after release.
- SYNC + byte 8'hC3 + EOP at 8 clk/bit → pkt_start ×1, rbyte_valid ×1 with rbyte = 8'hC3, pkt_end ×1, err = 0.
- Bytes 8'hFF, 8'h01 with a correct stuff bit → rbyte 8'hFF then 8'h01, err = 0.
- Seven consecutive ones without a stuff bit → err ×1, no further rbyte_valid, no pkt_end.
- 4-byte packet at 9 clk/bit, then at 7 clk/bit → all bytes correct; rx_ena dropped mid-packet → no pkt_end.
- With USB11_RECV_CRC16_EN:
  - bytes 4B 00 00 → crc_ok = 1 at pkt_end;
  - bytes 4B 00 01 → crc_ok = 0.

Source files
------------

// File: rtl/usb11_pkg.sv
// Shared line-state encodings, receiver states and CRC16 constants for the
// low-speed USB receive path.
package usb11_pkg;

    // Line state is packed as {dp, dm}.
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    localparam logic [2:0]  BIT_PHASE_SAMPLE = 3'd3;
    localparam logic [15:0] CRC16_POLY       = 16'h8005;
    localparam logic [15:0] CRC16_RESIDUAL   = 16'h800D;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_SYNC,
        RX_DATA,
        RX_EOP,
        RX_WAIT_IDLE
    } rx_state_t;

    // Folds one byte into the CRC, bit 0 first (wire order), MSB-shift form.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/usb11_rx_dpll.sv
// Bit-timing recovery: synchronises dp/dm, registers the line state and runs
// a 3-bit phase counter that re-centres on every J/K transition.
module usb11_rx_dpll
    import usb11_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       dp,
    input  logic       dm,
    output logic [1:0] line_state,
    output logic       sample
);
    logic [1:0] sync1_q, sync2_q, ls_q;
    logic [2:0] phase_q;
    logic       jk_edge;

    // Only J<->K changes carry timing; SE0/SE1 transitions leave the phase alone.
    assign jk_edge = (^sync2_q) && (^ls_q) && (sync2_q != ls_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= LS_J;
            sync2_q <= LS_J;
            ls_q    <= LS_J;
            phase_q <= 3'd0;
        end else begin
            sync1_q <= {dp, dm};
            sync2_q <= sync1_q;
            ls_q    <= sync2_q;
            phase_q <= jk_edge ? 3'd0 : phase_q + 3'd1;
        end
    end

    assign line_state = ls_q;
    assign sample     = (phase_q == BIT_PHASE_SAMPLE);

endmodule

// File: rtl/usb11_recv.sv
// Low-speed USB receiver: SYNC detect, NRZI decode, bit unstuffing, byte
// assembly and EOP check. Optional CRC16 check under USB11_RECV_CRC16_EN.
module usb11_recv
    import usb11_pkg::*;
#(
    parameter int SYNC_MIN_ZEROS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dp,
    input  logic       dm,
    input  logic       rx_ena,
    output logic [7:0] rbyte,
    output logic       rbyte_valid,
    output logic       pkt_start,
    output logic       pkt_end,
    output logic       err,
    output logic       crc_ok
);
    localparam logic [3:0] ZMIN = 4'(SYNC_MIN_ZEROS);

    logic [1:0] line_state;
    logic       sample;

    usb11_rx_dpll u_dpll (
        .clk        (clk),
        .rst        (rst),
        .dp         (dp),
        .dm         (dm),
        .line_state (line_state),
        .sample     (sample)
    );

    rx_state_t  state_q, state_n;
    logic [1:0] prev_q, prev_n, se0_q, se0_n;
    logic [3:0] zeros_q, zeros_n;
    logic [2:0] ones_q, ones_n, bcnt_q, bcnt_n, jcnt_q, jcnt_n;
    logic       seen_se0_q, seen_se0_n;
    logic [7:0] sr_q, sr_n, rbyte_q, rbyte_n;
    logic       rbyte_valid_n, pkt_start_n, pkt_end_n, err_n, crc_ok_n;
    logic       dbit, fault;

    assign dbit = (line_state == prev_q);

    // Outputs are one-cycle strobes registered from the sample that completes
    // them; there is no back-pressure, a consumer must take rbyte on rbyte_valid.
    always_comb begin
        state_n       = state_q;
        prev_n        = prev_q;
        zeros_n       = zeros_q;
        ones_n        = ones_q;
        bcnt_n        = bcnt_q;
        jcnt_n        = jcnt_q;
        se0_n         = se0_q;
        seen_se0_n    = seen_se0_q;
        sr_n          = sr_q;
        rbyte_n       = rbyte_q;
        rbyte_valid_n = 1'b0;
        pkt_start_n   = 1'b0;
        pkt_end_n     = 1'b0;
        err_n         = 1'b0;
        fault         = 1'b0;
        if (!rx_ena) begin
            state_n = RX_IDLE;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    if (line_state == LS_K) begin
                        state_n = RX_SYNC;
                        prev_n  = LS_J;
                        zeros_n = 4'd0;
                    end
                end
                RX_SYNC: if (sample) begin
                    if (line_state == LS_SE1)      fault   = 1'b1;
                    else if (line_state == LS_SE0) state_n = RX_IDLE;
                    else begin
                        prev_n = line_state;
                        if (!dbit) begin
                            zeros_n = (zeros_q == 4'hF) ? zeros_q : zeros_q + 4'd1;
                        end else if (zeros_q >= ZMIN) begin
                            state_n     = RX_DATA;
                            pkt_start_n = 1'b1;
                            ones_n      = 3'd0;
                            bcnt_n      = 3'd0;
                        end else begin
                            state_n = RX_IDLE;
                        end
                    end
                end
                RX_DATA: if (sample) begin
                    if (line_state == LS_SE1) fault = 1'b1;
                    else if (line_state == LS_SE0) begin
                        // A single dribble bit before EOP is tolerated and dropped.
                        if (bcnt_q <= 3'd1) begin
                            state_n = RX_EOP;
                            se0_n   = 2'd1;
                        end else begin
                            fault = 1'b1;
                        end
                    end else begin
                        prev_n = line_state;
                        if (ones_q == 3'd6) begin
                            if (dbit) fault  = 1'b1;
                            else      ones_n = 3'd0;
                        end else begin
                            ones_n = dbit ? ones_q + 3'd1 : 3'd0;
                            sr_n   = {dbit, sr_q[7:1]};
                            bcnt_n = bcnt_q + 3'd1;
                            if (bcnt_q == 3'd7) begin
                                rbyte_n       = sr_n;
                                rbyte_valid_n = 1'b1;
                            end
                        end
                    end
                end
                RX_EOP: if (sample) begin
                    if (line_state == LS_J) begin
                        pkt_end_n = 1'b1;
                        state_n   = RX_IDLE;
                    end else if (line_state == LS_SE0) begin
                        if (se0_q == 2'd3) state_n = RX_IDLE;
                        else               se0_n   = se0_q + 2'd1;
                    end else begin
                        fault = 1'b1;
                    end
                end
                RX_WAIT_IDLE: if (sample) begin
                    if (line_state == LS_J) begin
                        if (seen_se0_q || jcnt_q == 3'd7) state_n = RX_IDLE;
                        else                              jcnt_n  = jcnt_q + 3'd1;
                    end else begin
                        seen_se0_n = (line_state == LS_SE0);
                        jcnt_n     = 3'd0;
                    end
                end
                default: state_n = RX_IDLE;
            endcase
            if (fault) begin
                state_n    = RX_WAIT_IDLE;
                err_n      = 1'b1;
                jcnt_n     = 3'd0;
                seen_se0_n = 1'b0;
            end
        end
    end

`ifdef USB11_RECV_CRC16_EN
    logic [15:0] crc_q, crc_n;
    logic        pid_done_q, pid_done_n;

    // The first byte of every packet is the PID and stays out of the CRC.
    always_comb begin
        crc_n      = crc_q;
        pid_done_n = pid_done_q;
        if (pkt_start_n) begin
            crc_n      = 16'hFFFF;
            pid_done_n = 1'b0;
        end else if (rbyte_valid_n) begin
            if (pid_done_q) crc_n = crc16_byte(crc_q, rbyte_n);
            pid_done_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            crc_q      <= 16'hFFFF;
            pid_done_q <= 1'b0;
        end else begin
            crc_q      <= crc_n;
            pid_done_q <= pid_done_n;
        end
    end

    assign crc_ok_n = pkt_end_n && (crc_q == CRC16_RESIDUAL);
`else
    assign crc_ok_n = pkt_end_n;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RX_IDLE;
            prev_q      <= LS_J;
            zeros_q     <= 4'd0;
            ones_q      <= 3'd0;
            bcnt_q      <= 3'd0;
            jcnt_q      <= 3'd0;
            se0_q       <= 2'd0;
            seen_se0_q  <= 1'b0;
            sr_q        <= 8'h00;
            rbyte_q     <= 8'h00;
            rbyte_valid <= 1'b0;
            pkt_start   <= 1'b0;
            pkt_end     <= 1'b0;
            err         <= 1'b0;
            crc_ok      <= 1'b0;
        end else begin
            state_q     <= state_n;
            prev_q      <= prev_n;
            zeros_q     <= zeros_n;
            ones_q      <= ones_n;
            bcnt_q      <= bcnt_n;
            jcnt_q      <= jcnt_n;
            se0_q       <= se0_n;
            seen_se0_q  <= seen_se0_n;
            sr_q        <= sr_n;
            rbyte_q     <= rbyte_n;
            rbyte_valid <= rbyte_valid_n;
            pkt_start   <= pkt_start_n;
            pkt_end     <= pkt_end_n;
            err         <= err_n;
            crc_ok      <= crc_ok_n;
        end
    end

    assign rbyte = rbyte_q;

endmodule
